wbuf_weight_loader: RTL and testbench

- Read-side feeder for the per-column weight buffers of the systolic array with weight sparsity.
- On a start command, fetches a block of weight words from the weight SRAM (1-cycle read latency) and streams them onto the WBUF write interface.
- Steers the words round-robin across ARRAY_SIZE columns.
- Zero weights are forwarded as literal zeros so the buffers' zero-select path applies. Nonzero and zero weights are counted for sparsity statistics.

---
 rtl/wbuf_weight_loader.sv | 169 ++++++++++++++++
 tb/tb_wbuf_weight_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_weight_loader.sv
// Weight-SRAM reader that streams a block of weights round-robin into the
// per-column WBUFs, with a one-entry skid buffer and sparsity counters.
module wbuf_weight_loader #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      num_words,
    input  logic                  hold,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  WBUF_wr_en,
    output logic [DATA_W-1:0]     WBUF_data_in,
    output logic [ARRAY_SIZE-1:0] wbuf_sel,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      nz_count,
    output logic [CNT_W-1:0]      zero_count
);

    localparam int LW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [CNT_W-1:0]      r_remain;
    logic [CNT_W-1:0]      r_left;
    logic                  r_rd_pend;
    logic                  r_skid_vld;
    logic [DATA_W-1:0]     r_skid_data;
    logic                  r_out_en;
    logic [DATA_W-1:0]     r_out_data;
    logic [ARRAY_SIZE-1:0] r_sel;
    logic [LW-1:0]         r_lane;
    logic [CNT_W-1:0]      r_nz;
    logic [CNT_W-1:0]      r_zero;

    logic                  w_issue;
    logic                  w_active;
    logic                  w_emit;
    logic [DATA_W-1:0]     w_emit_data;
    logic                  w_emit_zero;
    logic [LW-1:0]         w_lane_nxt;
    logic [ARRAY_SIZE-1:0] w_sel_oh;

    assign w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_issue     = (r_state == S_ISSUE) && !hold;
    // A held word in the skid always leaves before fresh SRAM data.
    assign w_emit      = w_active && !hold && (r_skid_vld || r_rd_pend);
    assign w_emit_data = r_skid_vld ? r_skid_data : mem_rd_data;
    assign w_emit_zero = (w_emit_data == '0);
    assign w_lane_nxt  = (r_lane == LW'(ARRAY_SIZE - 1)) ? '0 : r_lane + LW'(1);
    assign w_sel_oh    = ARRAY_SIZE'(1) << r_lane;

    assign mem_rd_en    = w_issue;
    assign mem_addr     = w_issue ? r_addr : '0;
    assign WBUF_wr_en   = r_out_en;
    assign WBUF_data_in = r_out_data;
    assign wbuf_sel     = r_sel;
    assign busy         = w_active;
    assign done         = (r_state == S_DONE);
    assign nz_count     = r_nz;
    assign zero_count   = r_zero;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            r_addr   <= base_addr;
                            r_remain <= num_words;
                            r_state  <= S_ISSUE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!hold) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_remain <= r_remain - CNT_W'(1);
                        if (r_remain == CNT_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_left == '0 && !r_skid_vld && !r_rd_pend) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_rd_pend   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
        end else begin
            r_rd_pend <= w_issue;
            if (hold) begin
                if (r_rd_pend) begin
                    r_skid_vld  <= 1'b1;
                    r_skid_data <= mem_rd_data;
                end
            end else if (r_skid_vld) begin
                if (r_rd_pend) begin
                    r_skid_data <= mem_rd_data;
                end else begin
                    r_skid_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_out_en   <= 1'b0;
            r_out_data <= '0;
            r_sel      <= '0;
            r_lane     <= '0;
            r_left     <= '0;
            r_nz       <= '0;
            r_zero     <= '0;
        end else if (r_state == S_IDLE) begin
            r_out_en <= 1'b0;
            r_sel    <= '0;
            if (start && num_words != '0) begin
                r_lane <= '0;
                r_left <= num_words;
                r_nz   <= '0;
                r_zero <= '0;
            end
        end else if (w_emit) begin
            r_out_en   <= 1'b1;
            r_out_data <= w_emit_data;
            r_sel      <= w_sel_oh;
            r_lane     <= w_lane_nxt;
            r_left     <= r_left - CNT_W'(1);
            if (w_emit_zero) begin
                if (r_zero != '1) r_zero <= r_zero + CNT_W'(1);
            end else begin
                if (r_nz != '1) r_nz <= r_nz + CNT_W'(1);
            end
        end else begin
            r_out_en <= 1'b0;
            r_sel    <= '0;
        end
    end

endmodule

// File: tb/tb_wbuf_weight_loader.sv
// Self-checking bench for wbuf_weight_loader: table of loads plus
// hand-written sequences, with a read/emit scoreboard queue.
module tb_wbuf_weight_loader;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] num_words;
    logic        hold;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        WBUF_wr_en;
    logic [31:0] WBUF_data_in;
    logic [3:0]  wbuf_sel;
    logic        busy;
    logic        done;
    logic [15:0] nz_count;
    logic [15:0] zero_count;

    wbuf_weight_loader #(
        .ARRAY_SIZE(4), .DATA_W(32), .ADDR_W(10), .CNT_W(16)
    ) dut (
        .clk(clk), .nRST(nRST), .start(start),
        .base_addr(base_addr), .num_words(num_words), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .WBUF_wr_en(WBUF_wr_en),
        .WBUF_data_in(WBUF_data_in), .wbuf_sel(wbuf_sel),
        .busy(busy), .done(done),
        .nz_count(nz_count), .zero_count(zero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] sram [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram[mem_addr];

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    logic [31:0] q[$];
    logic [9:0]  exp_addr;
    int          lane_m;
    int          rd_cnt, wr_cnt;
    int          first_rd, first_wr, last_wr;

    always @(negedge clk) begin
        if (nRST) begin
            if (mem_rd_en) begin
                chk("rd_under_hold", {31'b0, hold}, 32'd0);
                chk("rd_addr", {22'b0, mem_addr}, {22'b0, exp_addr});
                q.push_back(sram[mem_addr]);
                chk("inflight_le3", {31'b0, q.size() > 3}, 32'd0);
                exp_addr = exp_addr + 10'd1;
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (WBUF_wr_en) begin
                chk("wr_while_busy", {31'b0, busy}, 32'd1);
                if (q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    chk("wr_data", WBUF_data_in, q.pop_front());
                    chk("wr_sel", {28'b0, wbuf_sel}, 32'd1 << lane_m);
                end
                lane_m = (lane_m + 1) % 4;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr_cnt++;
            end
        end
    end

    function automatic logic [31:0] pat(int p, int i);
        logic [31:0] basic [8];
        basic = '{32'd1, 32'd0, 32'd3, 32'd0, 32'd5, 32'd6, 32'd0, 32'd8};
        if (p == 0) return basic[i % 8];
        if (p == 1) return 32'd0;
        return (i % 3 == 0) ? 32'd0 : 32'hA5A5_0000 + i;
    endfunction

    typedef struct {
        logic [9:0] base;
        int         num;
        int         hafter;
        int         hlen;
        int         pat;
        int         poke;
        bit         sdone;
        bit         lat;
        int         enz;
        int         ez;
    } vec_t;

    vec_t tv [7];

    task automatic clr_sb(logic [9:0] base);
        q.delete();
        exp_addr = base;
        lane_m   = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        first_rd = -1;
        first_wr = -1;
        last_wr  = -1;
    endtask

    task automatic run_load(vec_t v);
        int  hleft;
        bit  hfired;
        bit  seen;
        int  rd0;
        hleft  = 0;
        hfired = 0;
        seen   = 0;
        for (int i = 0; i < v.num; i++)
            sram[(v.base + 10'(i)) & 10'h3FF] = pat(v.pat, i);
        @(posedge clk); #1;
        clr_sb(v.base);
        start     = 1'b1;
        base_addr = v.base;
        num_words = 16'(v.num);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (v.poke != 0 && i == v.poke) begin
                start     = 1'b1;
                base_addr = 10'h300;
                num_words = 16'd3;
            end
            if (hold) begin
                hleft--;
                if (hleft == 0) hold = 1'b0;
            end else if (!hfired && v.hafter != 0 && rd_cnt == v.hafter) begin
                hold   = 1'b1;
                hleft  = v.hlen;
                hfired = 1;
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("done_wr_en", {31'b0, WBUF_wr_en}, 32'd0);
        chk("nz_count", {16'b0, nz_count}, 32'(v.enz));
        chk("zero_count", {16'b0, zero_count}, 32'(v.ez));
        chk("rd_total", 32'(rd_cnt), 32'(v.num));
        chk("wr_total", 32'(wr_cnt), 32'(v.num));
        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("done_lat", 32'(cyc - last_wr), 32'd1);
        if (v.lat) chk("first_lat", 32'(first_wr - first_rd), 32'd2);
        if (v.sdone) begin
            start     = 1'b1;
            base_addr = 10'h000;
            num_words = 16'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        rd0 = rd_cnt;
        @(negedge clk);
        chk("done_pulse1", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        if (v.sdone) begin
            repeat (4) @(negedge clk);
            chk("start_in_done_ign", 32'(rd_cnt), 32'(rd0));
            chk("start_in_done_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        bit   got;
        int   r0, w0;
        tv[0] = '{10'h010, 8, 0, 0, 0, 0, 1'b0, 1'b1, 5, 3};
        tv[1] = '{10'h010, 8, 2, 3, 0, 0, 1'b0, 1'b0, 5, 3};
        tv[2] = '{10'h3FE, 4, 0, 0, 2, 0, 1'b0, 1'b1, 2, 2};
        tv[3] = '{10'h100, 6, 0, 0, 1, 0, 1'b0, 1'b0, 0, 6};
        tv[4] = '{10'h200, 1, 0, 0, 0, 0, 1'b1, 1'b1, 1, 0};
        tv[5] = '{10'h050, 5, 5, 2, 2, 0, 1'b0, 1'b0, 3, 2};
        tv[6] = '{10'h010, 8, 0, 0, 0, 4, 1'b0, 1'b0, 5, 3};
        for (int i = 0; i < 1024; i++) sram[i] = 32'hDEAD_0000 | i;

        nRST      = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        hold      = 1'b0;
        clr_sb(10'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'b0, WBUF_wr_en}, 32'd0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_counts", {nz_count, zero_count}, 32'd0);
        chk("rst_sel_data", {28'b0, wbuf_sel} | WBUF_data_in, 32'd0);
        nRST = 1'b1;

        for (int t = 0; t < 7; t++) run_load(tv[t]);

        // zero-length command goes straight to DONE
        @(posedge clk); #1;
        clr_sb(10'h005);
        start     = 1'b1;
        base_addr = 10'h005;
        num_words = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("zero_done_end", {31'b0, done}, 32'd0);
        chk("zero_no_rd", 32'(rd_cnt), 32'd0);
        chk("zero_no_wr", 32'(wr_cnt), 32'd0);

        // reset in the middle of an 8-word load
        v = tv[0];
        for (int i = 0; i < v.num; i++)
            sram[(v.base + 10'(i)) & 10'h3FF] = pat(v.pat, i);
        @(posedge clk); #1;
        clr_sb(v.base);
        start     = 1'b1;
        base_addr = v.base;
        num_words = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (wr_cnt >= 3) begin
                got = 1;
                break;
            end
        end
        chk("rst_mid_reached", {31'b0, got}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("mid_rst_wr_en", {31'b0, WBUF_wr_en}, 32'd0);
        chk("mid_rst_busy", {30'b0, busy, done}, 32'd0);
        chk("mid_rst_counts", {nz_count, zero_count}, 32'd0);
        chk("mid_rst_sel", {28'b0, wbuf_sel} | WBUF_data_in, 32'd0);
        @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
        q.delete();
        r0 = rd_cnt;
        w0 = wr_cnt;
        repeat (6) @(negedge clk);
        chk("post_rst_no_rd", 32'(rd_cnt), 32'(r0));
        chk("post_rst_no_wr", 32'(wr_cnt), 32'(w0));
        chk("post_rst_idle", {31'b0, busy}, 32'd0);
        run_load(tv[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
